// File: rtl/vga_sync_gen.sv
`timescale 1ns/1ps
// vga_sync_gen: raster timing generator for a VGA scan.
// Free-running pixel/line counters are decoded into syncs, a visible-area
// flag, coordinates and line/frame start pulses. Every output is registered
// one pixelclock edge behind the counter state it describes. CW must be wide
// enough to hold H_TOTAL-1 and V_TOTAL-1, and H_SYNC/V_SYNC must be >= 1.
module vga_sync_gen #(
    parameter int H_VIS       = 640,
    parameter int H_FP        = 16,
    parameter int H_SYNC      = 96,
    parameter int H_BP        = 48,
    parameter int V_VIS       = 480,
    parameter int V_FP        = 10,
    parameter int V_SYNC      = 2,
    parameter int V_BP        = 33,
    parameter bit SYNC_ACTIVE = 1'b0,
    parameter int CW          = 10
) (
    input  logic          pixelclock,
    input  logic          reset_n,
    output logic          hsinc,
    output logic          vsinc,
    output logic          draw,
    output logic [CW-1:0] x,
    output logic [CW-1:0] y,
    output logic          line_start,
    output logic          frame_start
);

    localparam int H_TOTAL = H_VIS + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_VIS + V_FP + V_SYNC + V_BP;

    // Decode thresholds, sized to the counters so comparisons stay CW wide.
    // Sync windows use an inclusive last index so a zero back porch cannot
    // push the end value past the counter range.
    localparam logic [CW-1:0] H_LAST    = CW'(H_TOTAL - 1);
    localparam logic [CW-1:0] V_LAST    = CW'(V_TOTAL - 1);
    localparam logic [CW-1:0] H_VIS_C   = CW'(H_VIS);
    localparam logic [CW-1:0] V_VIS_C   = CW'(V_VIS);
    localparam logic [CW-1:0] HS_FIRST  = CW'(H_VIS + H_FP);
    localparam logic [CW-1:0] HS_LAST   = CW'(H_VIS + H_FP + H_SYNC - 1);
    localparam logic [CW-1:0] VS_FIRST  = CW'(V_VIS + V_FP);
    localparam logic [CW-1:0] VS_LAST   = CW'(V_VIS + V_FP + V_SYNC - 1);

    // Raster position counters
    logic [CW-1:0] hc_q, hc_d;
    logic [CW-1:0] vc_q, vc_d;

    // Registered outputs
    logic          hsinc_q, hsinc_d;
    logic          vsinc_q, vsinc_d;
    logic          draw_q, draw_d;
    logic [CW-1:0] x_q, x_d;
    logic [CW-1:0] y_q, y_d;
    logic          line_start_q, line_start_d;
    logic          frame_start_q, frame_start_d;

    // Sync window membership of the current position
    logic          h_in_sync;
    logic          v_in_sync;

    // Counter stepping: hc wraps at end of line and carries into vc, which
    // wraps at end of frame.
    always_comb begin
        hc_d = hc_q + 1'b1;
        vc_d = vc_q;
        if (hc_q == H_LAST) begin
            hc_d = '0;
            if (vc_q == V_LAST) begin
                vc_d = '0;
            end else begin
                vc_d = vc_q + 1'b1;
            end
        end
    end

    // Decode the current position into the values the outputs take next edge.
    always_comb begin
        h_in_sync     = (hc_q >= HS_FIRST) && (hc_q <= HS_LAST);
        v_in_sync     = (vc_q >= VS_FIRST) && (vc_q <= VS_LAST);
        hsinc_d       = h_in_sync ? SYNC_ACTIVE : ~SYNC_ACTIVE;
        vsinc_d       = v_in_sync ? SYNC_ACTIVE : ~SYNC_ACTIVE;
        draw_d        = (hc_q < H_VIS_C) && (vc_q < V_VIS_C);
        x_d           = hc_q;
        y_d           = vc_q;
        line_start_d  = (hc_q == '0);
        frame_start_d = (hc_q == '0) && (vc_q == '0);
    end

    // Counter registers; reset parks the raster at (0,0) so the first edge
    // after release is the first pixel of a fresh frame.
    always_ff @(posedge pixelclock or negedge reset_n) begin
        if (!reset_n) begin
            hc_q <= '0;
            vc_q <= '0;
        end else begin
            hc_q <= hc_d;
            vc_q <= vc_d;
        end
    end

    // ---- output stage: one edge behind the counters, all outputs aligned ----
    // Output registers; reset drives every output to its idle level.
    always_ff @(posedge pixelclock or negedge reset_n) begin
        if (!reset_n) begin
            hsinc_q       <= ~SYNC_ACTIVE;
            vsinc_q       <= ~SYNC_ACTIVE;
            draw_q        <= 1'b0;
            x_q           <= '0;
            y_q           <= '0;
            line_start_q  <= 1'b0;
            frame_start_q <= 1'b0;
        end else begin
            hsinc_q       <= hsinc_d;
            vsinc_q       <= vsinc_d;
            draw_q        <= draw_d;
            x_q           <= x_d;
            y_q           <= y_d;
            line_start_q  <= line_start_d;
            frame_start_q <= frame_start_d;
        end
    end

    assign hsinc       = hsinc_q;
    assign vsinc       = vsinc_q;
    assign draw        = draw_q;
    assign x           = x_q;
    assign y           = y_q;
    assign line_start  = line_start_q;
    assign frame_start = frame_start_q;

endmodule
